// File: rtl/usbdev_iomux_sw.sv
// USB PHY IO mux: engine/override source select with drained, guarded switchover,
// plus RX synchronisers and a debounced VBUS sense.
module usbdev_iomux_sw #(
  parameter int SyncStages   = 2,
  parameter int FilterCycles = 16,
  parameter int GuardCycles  = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ovr_en_i,
  input  logic ovr_dp_i,
  input  logic ovr_dn_i,
  input  logic ovr_d_i,
  input  logic ovr_se0_i,
  input  logic ovr_oe_i,
  input  logic ovr_dp_pullup_i,
  input  logic ovr_dn_pullup_i,
  input  logic ovr_rx_enable_i,
  input  logic eng_dp_i,
  input  logic eng_dn_i,
  input  logic eng_d_i,
  input  logic eng_se0_i,
  input  logic eng_oe_i,
  input  logic eng_dp_pullup_i,
  input  logic eng_dn_pullup_i,
  input  logic eng_rx_enable_i,
  input  logic usb_rx_dp_i,
  input  logic usb_rx_dn_i,
  input  logic usb_rx_d_i,
  input  logic cio_usb_sense_i,
  output logic usb_tx_dp_o,
  output logic usb_tx_dn_o,
  output logic usb_tx_d_o,
  output logic usb_tx_se0_o,
  output logic usb_tx_oe_o,
  output logic usb_dp_pullup_en_o,
  output logic usb_dn_pullup_en_o,
  output logic usb_rx_enable_o,
  output logic usb_rx_dp_o,
  output logic usb_rx_dn_o,
  output logic usb_rx_d_o,
  output logic usb_pwr_sense_raw_o,
  output logic usb_pwr_sense_o,
  output logic ovr_active_o,
  output logic switch_busy_o
);

  localparam int GW = $clog2(GuardCycles + 1);
  localparam int FW = $clog2(FilterCycles + 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GuardCycles - 1);
  localparam logic [GW-1:0] GUARD_ONE  = GW'(1);
  localparam logic [FW-1:0] FILT_LAST  = FW'(FilterCycles - 1);
  localparam logic [FW-1:0] FILT_ONE   = FW'(1);
  // TX vectors are {dp, dn, d, se0, oe}; idle is J-like with the driver off.
  localparam logic [4:0] TX_IDLE = 5'b10100;

  typedef enum logic [2:0] {
    ST_ENGINE    = 3'd0,
    ST_DRAIN     = 3'd1,
    ST_GUARD_OVR = 3'd2,
    ST_OVR       = 3'd3,
    ST_GUARD_ENG = 3'd4
  } state_e;

  // Switch handshake: ovr_en_i is a level request; ovr_active_o is the grant and
  // rises only after the engine has drained and the guard interval has elapsed.
  state_e          state_q;
  logic [GW-1:0]   guard_cnt_q;
  logic [4:0]      tx_q;
  logic [2:0]      ctl_q;
  logic            busy_q;
  logic            active_q;
  logic [4:0]      eng_tx, ovr_tx;
  logic [2:0]      eng_ctl, ovr_ctl;

  assign eng_tx  = {eng_dp_i, eng_dn_i, eng_d_i, eng_se0_i, eng_oe_i};
  assign ovr_tx  = {ovr_dp_i, ovr_dn_i, ovr_d_i, ovr_se0_i, ovr_oe_i};
  assign eng_ctl = {eng_dp_pullup_i, eng_dn_pullup_i, eng_rx_enable_i};
  assign ovr_ctl = {ovr_dp_pullup_i, ovr_dn_pullup_i, ovr_rx_enable_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_ENGINE;
      guard_cnt_q <= '0;
      tx_q        <= TX_IDLE;
      ctl_q       <= '0;
      busy_q      <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      // Pullups and rx_enable simply hold while a guard state is active.
      case (state_q)
        ST_ENGINE, ST_DRAIN: begin
          tx_q  <= eng_tx;
          ctl_q <= eng_ctl;
        end
        ST_OVR: begin
          tx_q  <= ovr_tx;
          ctl_q <= ovr_ctl;
        end
        default: tx_q <= TX_IDLE;
      endcase
      busy_q   <= (state_q == ST_DRAIN) || (state_q == ST_GUARD_OVR) ||
                  (state_q == ST_GUARD_ENG);
      active_q <= (state_q == ST_OVR);

      case (state_q)
        ST_ENGINE: begin
          if (ovr_en_i) begin
            state_q     <= eng_oe_i ? ST_DRAIN : ST_GUARD_OVR;
            guard_cnt_q <= '0;
          end
        end
        ST_DRAIN: begin
          if (!ovr_en_i) begin
            state_q <= ST_ENGINE;
          end else if (!eng_oe_i) begin
            state_q     <= ST_GUARD_OVR;
            guard_cnt_q <= '0;
          end
        end
        ST_GUARD_OVR: begin
          if (!ovr_en_i) begin
            state_q     <= ST_GUARD_ENG;
            guard_cnt_q <= '0;
          end else if (guard_cnt_q == GUARD_LAST) begin
            state_q     <= ST_OVR;
            guard_cnt_q <= '0;
          end else begin
            guard_cnt_q <= guard_cnt_q + GUARD_ONE;
          end
        end
        ST_OVR: begin
          if (!ovr_en_i) begin
            state_q     <= ST_GUARD_ENG;
            guard_cnt_q <= '0;
          end
        end
        ST_GUARD_ENG: begin
          if (ovr_en_i) begin
            state_q     <= ST_GUARD_OVR;
            guard_cnt_q <= '0;
          end else if (guard_cnt_q == GUARD_LAST) begin
            state_q     <= ST_ENGINE;
            guard_cnt_q <= '0;
          end else begin
            guard_cnt_q <= guard_cnt_q + GUARD_ONE;
          end
        end
        default: begin
          state_q     <= ST_ENGINE;
          guard_cnt_q <= '0;
        end
      endcase
    end
  end

  // Synchroniser lanes are {dp, dn, d, sense}.
  logic [3:0]    sync_q [SyncStages];
  logic [3:0]    sync_out;
  logic          sense_prev_q;
  logic          sense_filt_q;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;

  assign sync_out = sync_q[SyncStages-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SyncStages; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {usb_rx_dp_i, usb_rx_dn_i, usb_rx_d_i, cio_usb_sense_i};
      for (int i = 1; i < SyncStages; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // filt_cnt_d equals the number of stable cycles so far minus one, saturating.
  always_comb begin
    filt_cnt_d = filt_cnt_q;
    if (sync_out[0] != sense_prev_q) filt_cnt_d = '0;
    else if (filt_cnt_q != FILT_LAST) filt_cnt_d = filt_cnt_q + FILT_ONE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sense_prev_q <= 1'b0;
      sense_filt_q <= 1'b0;
      filt_cnt_q   <= '0;
    end else begin
      sense_prev_q <= sync_out[0];
      filt_cnt_q   <= filt_cnt_d;
      if (filt_cnt_d == FILT_LAST) sense_filt_q <= sync_out[0];
    end
  end

  assign {usb_tx_dp_o, usb_tx_dn_o, usb_tx_d_o, usb_tx_se0_o, usb_tx_oe_o} = tx_q;
  assign {usb_dp_pullup_en_o, usb_dn_pullup_en_o, usb_rx_enable_o}       = ctl_q;
  assign {usb_rx_dp_o, usb_rx_dn_o, usb_rx_d_o} = sync_out[3:1];
  assign usb_pwr_sense_raw_o = sync_out[0];
  assign usb_pwr_sense_o     = sense_filt_q;
  assign ovr_active_o        = active_q;
  assign switch_busy_o       = busy_q;

endmodule

// File: doc/usbdev_iomux_sw.md
# usbdev_iomux_sw

Parametrised USB PHY IO mux for the usbdev block. Selects between the USB engine and the register override path for all PHY outputs, with a glitch-free, handshaked switchover: it drains engine traffic, then holds a guarded idle interval before handing over the pins. It also synchronises the async PHY inputs with a configurable depth and debounces VBUS sense. It sits between the usbdev core and the pad/PHY wrapper.

## Interface
Parameters:
- SyncStages, 2, synchroniser depth for async inputs; legal range 2..4.
- FilterCycles, 16, consecutive stable cycles required before filtered VBUS sense changes; at least 1.
- GuardCycles, 4, idle cycles with OE forced low on every source switch; at least 1.

Ports:
- clk_i  in  1  usb clock; the only clock.
- rst_i  in  1  reset, asynchronous and active-high.
- ovr_en_i  in  1  override request from the register block.
- ovr_dp_i, ovr_dn_i, ovr_d_i, ovr_se0_i, ovr_oe_i  in  1 each  override TX values.
- ovr_dp_pullup_i, ovr_dn_pullup_i, ovr_rx_enable_i  in  1 each  override control values.
- eng_dp_i, eng_dn_i, eng_d_i, eng_se0_i, eng_oe_i  in  1 each  engine TX values.
- eng_dp_pullup_i, eng_dn_pullup_i, eng_rx_enable_i  in  1 each  engine control values.
- usb_rx_dp_i, usb_rx_dn_i, usb_rx_d_i, cio_usb_sense_i  in  1 each  async pad inputs.
- usb_tx_dp_o, usb_tx_dn_o, usb_tx_d_o, usb_tx_se0_o, usb_tx_oe_o  out  1 each  registered PHY TX outputs.
- usb_dp_pullup_en_o, usb_dn_pullup_en_o, usb_rx_enable_o  out  1 each  registered PHY control outputs.
- usb_rx_dp_o, usb_rx_dn_o, usb_rx_d_o  out  1 each  synchronised RX signals.
- usb_pwr_sense_raw_o  out  1  synchronised, unfiltered sense.
- usb_pwr_sense_o  out  1  debounced sense.
- ovr_active_o  out  1  high while the override source drives the pins.
- switch_busy_o  out  1  high in DRAIN, GUARD_OVR and GUARD_ENG.

## Operation
- FSM states: ENGINE (reset state), DRAIN, GUARD_OVR, OVR, GUARD_ENG.
- ENGINE: outputs follow the eng_* inputs.
  - When ovr_en_i=1 and eng_oe_i=1, go to DRAIN.
  - When ovr_en_i=1 and eng_oe_i=0, go to GUARD_OVR.
- DRAIN: outputs still follow the engine.
  - When eng_oe_i falls, go to GUARD_OVR.
  - When ovr_en_i drops, return to ENGINE.
- GUARD_OVR and GUARD_ENG are idle states. Outputs are forced to oe=0, dp=1, dn=0, d=1, se0=0.
  - Pullups and rx_enable hold their last registered values.
  - The guard counter counts GuardCycles cycles, then the FSM moves to OVR or ENGINE respectively.
- Abort during a guard: if ovr_en_i reverses during GUARD_OVR, go to GUARD_ENG with the counter restarted. GUARD_ENG with ovr_en_i=1 goes to GUARD_OVR with the counter restarted.
- OVR: outputs follow the ovr_* inputs. ovr_en_i=0 goes to GUARD_ENG. The engine never drives the pins while in OVR.
- Pullups and rx_enable switch source only on entry to OVR or ENGINE; they never switch inside a guard.
- RX path: all four pad inputs pass through SyncStages flops each. There is no source mux on RX.
- Sense filter: a counter of width $clog2(FilterCycles+1) restarts whenever the synced sense differs from its previous sample.
  - usb_pwr_sense_o takes the synced value once it has been stable for FilterCycles consecutive cycles.
  - The counter saturates and never wraps.

## Timing
- Reset values:
  - All TX outputs are in the idle pattern: oe=0, dp=1, dn=0, d=1, se0=0.
  - Pullups 0, rx_enable 0, usb_rx_* 0, both sense outputs 0, ovr_active_o 0, switch_busy_o 0.
  - The FSM is in ENGINE and all counters are 0.
- Every PHY output is a flop. Source input to pad output takes 1 cycle; there are no combinational paths from inputs to outputs.
- RX/sense latency is SyncStages cycles. Filtered sense adds FilterCycles cycles after the input stabilises.
- Minimum switch, starting from ENGINE with eng_oe_i=0: request in cycle 0, GUARD_OVR in cycles 1..GuardCycles, OVR state at cycle GuardCycles+1, override values at the pads one cycle later.
- ovr_active_o and switch_busy_o are registered decodes of the state.
- Asserting rst_i mid-switch immediately forces the reset values, asynchronously.

## Test plan
- Reset with rst_i=1 -> all outputs at the reset values, including tx_oe=0 and dp=1.
- ENGINE, eng_oe_i=0, pulse ovr_en_i=1 at cycle 0, GuardCycles=4 -> switch_busy_o high for 4 cycles, then ovr_active_o=1 and pads equal ovr_* one cycle after entering OVR.
- eng_oe_i=1 for 10 cycles while ovr_en_i=1 -> pads keep engine values through the drain with no oe glitch. The guard starts the cycle after eng_oe_i falls.
- ovr_en_i dropped at guard cycle 2 of GUARD_OVR -> FSM goes to GUARD_ENG and returns to ENGINE after 4 more cycles. usb_tx_oe_o stays 0 throughout.
- cio_usb_sense_i toggled every 5 cycles with FilterCycles=16 -> usb_pwr_sense_o stays 0. A hold at 1 gives usb_pwr_sense_o=1 exactly 16+SyncStages cycles after the last edge.
- Sweep SyncStages=2..4 -> usb_rx_dp_o follows usb_rx_dp_i with exactly SyncStages cycles latency.
